// File: rtl/mmcm_ps_sequencer.sv
// Sequences MMCM dynamic phase-shift steps per channel command, keeping a signed position per channel.
// psen one cycle after accept; cmd_ready only in IDLE; optional abort port under MMCM_PS_ABORT_EN.
module mmcm_ps_sequencer #(
   parameter int  N_CH           = 2,
   parameter int  STEP_W         = 16,
   parameter int  POS_W          = 16,
   parameter int  GAP_CYCLES     = 4,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CH_W-1:0]       cmd_ch,
   input  logic [STEP_W-1:0]     cmd_steps,
   input  logic                  cmd_dir,
`ifdef MMCM_PS_ABORT_EN
   input  logic                  abort,
`endif
   output logic [N_CH-1:0]       psen,
   output logic [N_CH-1:0]       psincdec,
   input  logic [N_CH-1:0]       psdone,
   output logic                  busy,
   output logic                  done,
   output logic                  err_timeout,
   output logic [N_CH*POS_W-1:0] phase_pos
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              dir_q, dir_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [POS_W-1:0]  pos_q [N_CH];
   logic [POS_W-1:0]  pos_d [N_CH];
   logic [N_CH-1:0]   psen_q, psen_d;
   logic [N_CH-1:0]   psincdec_q, psincdec_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rdy_q, rdy_d;
   logic              abort_now;

`ifdef MMCM_PS_ABORT_EN
   logic abort_pend_q, abort_pend_d;
   assign abort_now = abort | abort_pend_q;

   // An abort seen while a step is in flight is held until that step's psdone or timeout.
   always_comb begin
      abort_pend_d = abort_pend_q;
      if (state_d == S_IDLE)
         abort_pend_d = 1'b0;
      else if (state_q == S_PULSE || state_q == S_WAIT)
         abort_pend_d = abort_now;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) abort_pend_q <= 1'b0;
      else          abort_pend_q <= abort_pend_d;
   end
`else
   assign abort_now = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && rdy_q) begin
               ch_d  = cmd_ch;
               dir_d = cmd_dir;
               rem_d = cmd_steps;
               if (cmd_steps == '0 || int'(cmd_ch) >= N_CH) done_d  = 1'b1;
               else                                          state_d = S_PULSE;
            end
         end
         S_PULSE: begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
         end
         S_WAIT: begin
            if (psdone[ch_q]) begin
               pos_d[ch_q] = dir_q ? pos_q[ch_q] + POS_W'(1) : pos_q[ch_q] - POS_W'(1);
               rem_d       = rem_q - STEP_W'(1);
               if (rem_q == STEP_W'(1) || abort_now) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = CNT_W'(1);
               end
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (abort_now) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(GAP_CYCLES)) begin
               state_d = S_PULSE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so psen lands exactly in the PULSE cycle.
      psen_d     = '0;
      psincdec_d = '0;
      if (state_d == S_PULSE)  psen_d[ch_d]     = 1'b1;
      if (state_d != S_IDLE)   psincdec_d[ch_d] = dir_d;
      busy_d = (state_d != S_IDLE);
      rdy_d  = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         dir_q      <= 1'b0;
         rem_q      <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < N_CH; i++) pos_q[i] <= '0;
         psen_q     <= '0;
         psincdec_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         dir_q      <= dir_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         pos_q      <= pos_d;
         psen_q     <= psen_d;
         psincdec_q <= psincdec_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdy_q      <= rdy_d;
      end
   end

   assign cmd_ready   = rdy_q;
   assign psen        = psen_q;
   assign psincdec    = psincdec_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_pos
      assign phase_pos[g*POS_W +: POS_W] = pos_q[g];
   end

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Directed bench: a 2-channel/16-bit instance with a psdone responder model, and a
// 1-channel/4-bit instance driven by hand for position wrap and last-cycle psdone.
module tb_mmcm_ps_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [0:0]  cmd_ch;
   logic [15:0] cmd_steps;
   logic        cmd_dir;
   logic [1:0]  psen, psincdec;
   logic [1:0]  psdone = 2'b00;
   logic        busy, done, err_timeout;
   logic [31:0] phase_pos;
`ifdef MMCM_PS_ABORT_EN
   logic        abort;
   logic        abort4;
`endif

   logic        cmd_valid4;
   logic        cmd_ready4;
   logic [0:0]  cmd_ch4;
   logic [15:0] cmd_steps4;
   logic        cmd_dir4;
   logic [0:0]  psen4, psincdec4, psdone4;
   logic        busy4, done4, err4;
   logic [3:0]  phase_pos4;

   mmcm_ps_sequencer #(.N_CH(2), .STEP_W(16), .POS_W(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) u_dut (
      .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
`ifdef MMCM_PS_ABORT_EN
      .abort(abort),
`endif
      .psen(psen), .psincdec(psincdec), .psdone(psdone), .busy(busy), .done(done),
      .err_timeout(err_timeout), .phase_pos(phase_pos)
   );

   mmcm_ps_sequencer #(.N_CH(1), .STEP_W(16), .POS_W(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) u_dut4 (
      .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
      .cmd_ch(cmd_ch4), .cmd_steps(cmd_steps4), .cmd_dir(cmd_dir4),
`ifdef MMCM_PS_ABORT_EN
      .abort(abort4),
`endif
      .psen(psen4), .psincdec(psincdec4), .psdone(psdone4), .busy(busy4), .done(done4),
      .err_timeout(err4), .phase_pos(phase_pos4)
   );

   // psdone responder and activity monitor for u_dut, both evaluated mid-cycle
   bit          withhold = 1'b0;
   bit          noise_en = 1'b0;
   logic        noise_t  = 1'b0;
   int          mcnt[2]  = '{0, 0};
   logic [1:0]  mpulse;
   logic [1:0]  psen_prev = 2'b00;
   int          cyc = 0;
   int          psen_n[2] = '{0, 0};
   int          psen_wide = 0, done_n = 0, err_n = 0, sp_n = 0, sp_bad = 0, pd0_n = 0;
   bit          arm[2] = '{1'b0, 1'b0};
   int          tpd[2] = '{0, 0};

   always @(negedge clk) begin
      cyc++;
      mpulse = 2'b00;
      for (int c = 0; c < 2; c++) begin
         if (mcnt[c] > 0) begin
            mcnt[c]--;
            if (mcnt[c] == 0) mpulse[c] = 1'b1;
         end
         if (psen[c] && !withhold) mcnt[c] = 12;
      end
      noise_t = noise_en ? ~noise_t : 1'b0;
      psdone  = mpulse | {1'b0, noise_t};

      for (int c = 0; c < 2; c++) begin
         if (psen[c]) begin
            psen_n[c]++;
            if (psen_prev[c]) psen_wide++;
            if (arm[c]) begin
               sp_n++;
               if (cyc - tpd[c] != 5) sp_bad++;
               arm[c] = 1'b0;
            end
         end
         if (psdone[c] && busy && !noise_en) begin
            arm[c] = 1'b1;
            tpd[c] = cyc;
         end
      end
      if (psdone[0] && busy) pd0_n++;
      if (done || err_timeout) begin
         arm[0] = 1'b0;
         arm[1] = 1'b0;
      end
      done_n    += int'(done);
      err_n     += int'(err_timeout);
      psen_prev  = psen;
   end

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic ch, input logic [15:0] steps, input logic dir);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ch    = ch;
      cmd_steps = steps;
      cmd_dir   = dir;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send4(input logic ch, input logic [15:0] steps, input logic dir);
      @(negedge clk);
      cmd_valid4 = 1'b1;
      cmd_ch4    = ch;
      cmd_steps4 = steps;
      cmd_dir4   = dir;
      @(posedge clk);
      #1;
      cmd_valid4 = 1'b0;
   endtask

   task automatic wait_end(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk);
         #1;
         if (done || err_timeout) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Waits for a psen on u_dut4, then returns psdone k cycles after it.
   task automatic respond4(input int k, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (psen4[0]) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         repeat (k) @(negedge clk);
         psdone4 = 1'b1;
         @(negedge clk);
         psdone4 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int s_p0, s_p1, s_sp, s_done, s_err, s_pd, errs_seen;

      aresetn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_ch     = 1'b0;
      cmd_steps  = '0;
      cmd_dir    = 1'b0;
      cmd_valid4 = 1'b0;
      cmd_ch4    = 1'b0;
      cmd_steps4 = '0;
      cmd_dir4   = 1'b0;
      psdone4    = 1'b0;
`ifdef MMCM_PS_ABORT_EN
      abort      = 1'b0;
      abort4     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psen", 32'(psen), 0);
      chk("rst_psincdec", 32'(psincdec), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_pos", phase_pos, 0);
      @(negedge clk);
      aresetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(cmd_ready), 1);

      // ch0, 3 steps up
      s_p0 = psen_n[0]; s_p1 = psen_n[1]; s_sp = sp_n; s_done = done_n;
      send(1'b0, 16'd3, 1'b1);
      chk("t1_psen_first", 32'(psen), 32'h1);
      chk("t1_psincdec", 32'(psincdec), 32'h1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ready_low", 32'(cmd_ready), 0);
      wait_end(200, ok);
      chk("t1_end_seen", 32'(ok), 1);
      chk("t1_done", 32'(done), 1);
      chk("t1_ready_with_done", 32'(cmd_ready), 1);
      chk("t1_no_err", 32'(err_timeout), 0);
      @(posedge clk);
      #1;
      chk("t1_done_one_cycle", 32'(done), 0);
      chk("t1_psen_ch0_count", 32'(psen_n[0] - s_p0), 3);
      chk("t1_psen_ch1_count", 32'(psen_n[1] - s_p1), 0);
      chk("t1_psen_width", 32'(psen_wide), 0);
      chk("t1_spacing_count", 32'(sp_n - s_sp), 2);
      chk("t1_spacing_bad", 32'(sp_bad), 0);
      chk("t1_done_count", 32'(done_n - s_done), 1);
      chk("t1_pos0", 32'(phase_pos[15:0]), 32'h3);

      // ch1, 2 steps down, with noise on psdone[0]
      s_p0 = psen_n[0]; s_p1 = psen_n[1];
      noise_en = 1'b1;
      send(1'b1, 16'd2, 1'b0);
      chk("t2_psen_first", 32'(psen), 32'h2);
      chk("t2_psincdec_pulse", 32'(psincdec), 0);
      repeat (6) @(posedge clk);
      #1;
      chk("t2_busy_wait", 32'(busy), 1);
      chk("t2_psincdec_wait", 32'(psincdec), 0);
      wait_end(200, ok);
      noise_en = 1'b0;
      chk("t2_end_seen", 32'(ok), 1);
      chk("t2_done", 32'(done), 1);
      chk("t2_pos1", 32'(phase_pos[31:16]), 32'hFFFE);
      chk("t2_pos0", 32'(phase_pos[15:0]), 32'h3);
      chk("t2_psen_ch0_count", 32'(psen_n[0] - s_p0), 0);
      chk("t2_psen_ch1_count", 32'(psen_n[1] - s_p1), 2);

      // zero-step command
      s_p0 = psen_n[0];
      repeat (3) @(posedge clk);
      send(1'b0, 16'd0, 1'b1);
      chk("t3_psen", 32'(psen), 0);
      chk("t3_done", 32'(done), 1);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_ready", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      chk("t3_done_one_cycle", 32'(done), 0);
      chk("t3_busy_after", 32'(busy), 0);
      chk("t3_no_psen", 32'(psen_n[0] - s_p0), 0);

      // timeout with psdone withheld
      withhold = 1'b1;
      s_done = done_n;
      send(1'b0, 16'd1, 1'b1);
      errs_seen = 0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         if (err_timeout) errs_seen++;
      end
      chk("t4_no_early_err", 32'(errs_seen), 0);
      @(posedge clk);
      #1;
      chk("t4_err", 32'(err_timeout), 1);
      chk("t4_ready_with_err", 32'(cmd_ready), 1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_pos0", 32'(phase_pos[15:0]), 32'h3);
      withhold = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_err_one_cycle", 32'(err_timeout), 0);
      chk("t4_no_done", 32'(done_n - s_done), 0);

      // reset mid-WAIT
      send(1'b0, 16'd10, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_busy_before", 32'(busy), 1);
      @(negedge clk);
      aresetn = 1'b0;
      #1;
      chk("t5_psen", 32'(psen), 0);
      chk("t5_psincdec", 32'(psincdec), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_pos", phase_pos, 0);
      chk("t5_ready_in_rst", 32'(cmd_ready), 0);
      @(negedge clk);
      aresetn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("t5_ready_after", 32'(cmd_ready), 1);
      chk("t5_pos_after", phase_pos, 0);

      // 4-bit instance: out-of-range channel, wrap, psdone on last WAIT cycle
      send4(1'b1, 16'd3, 1'b1);
      chk("w_badch_psen", 32'(psen4), 0);
      chk("w_badch_done", 32'(done4), 1);
      chk("w_badch_busy", 32'(busy4), 0);
      send4(1'b0, 16'd7, 1'b1);
      for (int i = 0; i < 7; i++) begin
         respond4(2, ok);
         chk("w_step_psen_seen", 32'(ok), 1);
      end
      chk("w_seven_done", 32'(done4), 1);
      chk("w_pos7", 32'(phase_pos4), 32'h7);
      @(posedge clk);
      #1;
      send4(1'b0, 16'd1, 1'b1);
      respond4(64, ok);
      chk("w_last_psen_seen", 32'(ok), 1);
      chk("w_last_done", 32'(done4), 1);
      chk("w_last_no_err", 32'(err4), 0);
      chk("w_pos_wrap", 32'(phase_pos4), 32'h8);
      @(posedge clk);
      #1;
      chk("w_no_late_err", 32'(err4), 0);

`ifdef MMCM_PS_ABORT_EN
      // abort in GAP after step 2 of 5
      s_pd = pd0_n;
      send(1'b0, 16'd5, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (pd0_n - s_pd >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ab_two_steps", 32'(ok), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("ab_done", 32'(done), 1);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_pos0", 32'(phase_pos[15:0]), 32'h2);
`endif

      s_err = err_n;
      repeat (4) @(posedge clk);
      #1;
      chk("end_idle_no_err", 32'(err_n - s_err), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mmcm_ps_sequencer.md
Name: mmcm_ps_sequencer

Overview:
Parametrised successor to the periodic single-step phase-shift controller. Accepts commands of the form "shift channel C by N steps in direction D". Drives the dynamic phase-shift ports of N_CH MMCMs one step at a time, with a programmable gap between steps and a psdone timeout. Keeps a signed running phase position per channel. Sits between the timing-alignment logic and the mmcm wrappers; clk must also drive every MMCM PSCLK.

Parameters:
N_CH, 2, number of MMCM channels driven (1..8)
STEP_W, 16, width of the per-command step count
POS_W, 16, width of each signed phase-position accumulator
GAP_CYCLES, 4, clk cycles from a psdone to the next psen (>=1)
TIMEOUT_CYCLES, 64, max WAIT cycles for psdone before abort (>=16)

Ports:
clk  in  1  system clock, also PSCLK of all driven MMCMs
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  high in IDLE only
cmd_ch  in  max(1,$clog2(N_CH))  target channel
cmd_steps  in  STEP_W  number of steps, 0 allowed
cmd_dir  in  1  1 = increment, 0 = decrement
psen  out  N_CH  per-channel PSEN, one-cycle pulses
psincdec  out  N_CH  per-channel PSINCDEC
psdone  in  N_CH  per-channel PSDONE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, command completed
err_timeout  out  1  one-cycle pulse, command aborted on timeout
phase_pos  out  N_CH*POS_W  signed position per channel, ch0 in LSBs

Behaviour:
- Reset is asynchronous, active-low. All outputs are registered and drive 0 during reset: psen, psincdec, busy, done, err_timeout and phase_pos. cmd_ready is 1 once the block is out of reset.
- States: IDLE, PULSE, WAIT, GAP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch ch, steps and dir.
  - steps==0: stay IDLE; done pulses the next cycle; no psen.
  - cmd_ch >= N_CH: treated as steps==0.
  - Otherwise go to PULSE.
- PULSE (1 cycle): psen[ch]=1 and psincdec[ch]=dir, both registered; next state WAIT. Accept at cycle T gives psen high at T+1.
- psincdec[ch] holds dir from PULSE until the command ends. psincdec of other channels is 0.
- WAIT: the timeout counter is 1 in the first WAIT cycle and increments every cycle. Only psdone[ch] is observed; psdone on other channels is ignored.
  - On psdone[ch]: phase_pos[ch] += dir ? +1 : -1, in two's complement, wrapping modulo 2^POS_W. remaining is decremented.
  - If remaining becomes 0: go to IDLE and pulse done the next cycle. Otherwise go to GAP.
  - If the counter reaches TIMEOUT_CYCLES with no psdone[ch] that cycle: pulse err_timeout, go to IDLE, position unchanged. If psdone and the timeout coincide, psdone wins.
- GAP: lasts exactly GAP_CYCLES cycles, then PULSE. The psdone-to-psen spacing is GAP_CYCLES+1.
- The per-command step count is at most 2^STEP_W-1. There is no saturation of phase_pos.
- A new command is never accepted while busy. cmd_ready goes high in the same cycle as the done or err_timeout pulse.
- Reset asserted mid-command: the command is dropped immediately and phase_pos clears. The team's software re-centres the MMCM after any reset.

Optional Feature:
Macro MMCM_PS_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort in GAP: return to IDLE next cycle and pulse done; position reflects steps already completed.
  - abort in PULSE or WAIT: latched and honoured after the in-flight psdone (or timeout), because the MMCM requires psdone before further PS activity.
  - abort in IDLE is ignored.
- Undefined: no abort port; commands always run to completion or timeout.

Test Plan:
- Reset, then cmd ch=0 steps=3 dir=1; model returns psdone 12 cycles after each psen -> 3 psen pulses on ch0 only, each one cycle wide. Spacing psdone->psen is 5 cycles. done pulses once. phase_pos[0]=+3.
- cmd ch=1 steps=2 dir=0 from pos 0 -> psincdec[1]=0 during the command, phase_pos[1]=-2, phase_pos[0] unchanged; psdone[0] toggled during the command is ignored.
- steps=0 command -> no psen, done one cycle after accept, busy stays 0.
- Model withholds psdone -> err_timeout exactly 64 cycles after entering WAIT, phase_pos unchanged, cmd_ready=1 in the same cycle.
- POS_W=4, pos=+7, cmd +1 -> phase_pos wraps to -8. psdone arriving on exactly the 64th WAIT cycle -> counted, no err_timeout.
- aresetn dropped mid-WAIT of a 10-step command -> psen, busy and phase_pos are 0 immediately. With MMCM_PS_ABORT_EN, abort in GAP after step 2 of 5 -> done pulse, phase_pos=2.
